// File: rtl/mem_responder_pkg.sv
// Shared types and default sizing for the mem_responder block.
package mem_responder_pkg;

  localparam int ADDR_W_DEF    = 15;
  localparam int DATA_W_DEF    = 32;
  localparam int BLK_WORDS_DEF = 4;
  localparam int BLK_OFF_W     = $clog2(BLK_WORDS_DEF);
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    WDONE
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the cache control unit (master) and mem_responder (slave).
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BLK_WORDS = BLK_WORDS_DEF
);

  logic                        rRead;
  logic                        rWrite;
  logic [ADDR_W-1:0]           addr;
  logic [DATA_W-1:0]           wData;
  logic [DATA_W*BLK_WORDS-1:0] rData;
  logic                        ready;
  logic                        busy;

  modport master (output rRead, rWrite, addr, wData, input rData, ready, busy);
  modport slave  (input rRead, rWrite, addr, wData, output rData, ready, busy);

endinterface

// File: rtl/mem_latency_counter.sv
// Loadable down-counter timing the read wait; zero flags the last wait cycle.
module mem_latency_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] loadVal,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_responder.sv
// Block-read memory responder with a fixed read latency; single-word writes
// are available only when MEM_RESPONDER_WRITE_EN is defined.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BLK_WORDS = BLK_WORDS_DEF,
  parameter int LATENCY   = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t                      state, nextState;
  logic [ADDR_W-1:0]           baseAddr;
  logic [DATA_W*BLK_WORDS-1:0] blkWords;
  logic                        cntLoad, cntDec, cntZero, dataLoad;

  mem_latency_counter #(.W(CNT_W)) waitCnt (
    .clk    (clk),
    .rst    (rst),
    .load   (cntLoad),
    .dec    (cntDec),
    .loadVal(CNT_W'(LATENCY - 1)),
    .zero   (cntZero)
  );

`ifdef MEM_RESPONDER_WRITE_EN
  // Words never written still read back as their own index, so only written ones come from mem.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written = '0;
  logic              acceptWrite;

  assign acceptWrite = !rst && state == IDLE && bus.rWrite && !bus.rRead;

  always_ff @(posedge clk) begin
    if (acceptWrite) begin
      mem[bus.addr]     <= bus.wData;
      written[bus.addr] <= 1'b1;
    end
  end

  always_comb begin
    blkWords = '0;
    for (int k = 0; k < BLK_WORDS; k++) begin
      blkWords[k*DATA_W +: DATA_W] = written[baseAddr + ADDR_W'(k)]
                                   ? mem[baseAddr + ADDR_W'(k)]
                                   : DATA_W'(baseAddr + ADDR_W'(k));
    end
  end
`else
  logic unusedWrite;
  assign unusedWrite = ^{bus.rWrite, bus.wData};

  always_comb begin
    blkWords = '0;
    for (int k = 0; k < BLK_WORDS; k++) begin
      blkWords[k*DATA_W +: DATA_W] = DATA_W'(baseAddr + ADDR_W'(k));
    end
  end
`endif

  always_comb begin
    nextState = state;
    cntLoad   = 1'b0;
    cntDec    = 1'b0;
    dataLoad  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rRead) begin
          nextState = WAIT;
          cntLoad   = 1'b1;
        end
`ifdef MEM_RESPONDER_WRITE_EN
        else if (bus.rWrite) begin
          nextState = WDONE;
        end
`endif
      end
      WAIT: begin
        if (cntZero) begin
          nextState = RESP;
          dataLoad  = 1'b1;
        end else begin
          cntDec = 1'b1;
        end
      end
      RESP:    nextState = IDLE;
      WDONE:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // The block base is latched once at acceptance; later addr changes never reach the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baseAddr  <= '0;
      bus.rData <= '0;
    end else begin
      state <= nextState;
      if (cntLoad) begin
        baseAddr <= bus.addr & ~ADDR_W'(BLK_WORDS - 1);
      end
      if (dataLoad) begin
        bus.rData <= blkWords;
      end
    end
  end

  assign bus.ready = (state == RESP) || (state == WDONE);
  assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random reads
// against a word-array reference model.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 32;
  localparam int BLK_WORDS = 4;
  localparam int LATENCY   = 4;
  localparam int DEPTH     = 2 ** ADDR_W;
  localparam int BLK_BITS  = DATA_W * BLK_WORDS;

  logic clk = 1'b0;
  logic rst;

  mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLK_WORDS(BLK_WORDS)) bus ();

  mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLK_WORDS(BLK_WORDS), .LATENCY(LATENCY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0]   refMem [DEPTH];
  logic [BLK_BITS-1:0] lastBlock;
  int                  vecCount  = 0;
  int                  missCount = 0;

  function automatic logic [BLK_BITS-1:0] refBlock(input logic [ADDR_W-1:0] a);
    logic [BLK_BITS-1:0] r;
    int base;
    base = (int'(a) >> BLK_OFF_W) << BLK_OFF_W;
    r = '0;
    for (int k = 0; k < BLK_WORDS; k++) r[k*DATA_W +: DATA_W] = refMem[(base + k) % DEPTH];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [BLK_BITS-1:0] obs,
                             input logic [BLK_BITS-1:0] exp);
    vecCount++;
    assert (obs === exp) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] wd);
    bus.rRead  = rd;
    bus.rWrite = wr;
    bus.addr   = a;
    bus.wData  = wd;
  endtask

  // Starts in an IDLE cycle just after a rising edge; ends just after the edge following ready.
  task automatic readTxn(input logic [ADDR_W-1:0] a, input bit wr, input bit toggle,
                         input bit keepReq, input string tag);
    logic [BLK_BITS-1:0] expBlock;
    int cyc;
    bit seen;
    expBlock = refBlock(a);
    applyStimulus(1'b1, wr, a, DATA_W'($urandom));
    cyc  = 0;
    seen = 1'b0;
    while (cyc <= LATENCY + 4) begin
      @(negedge clk);
      if (bus.ready) begin
        seen = 1'b1;
        break;
      end
      checkOutput({tag, "_busy"}, bus.busy, cyc != 0);
      @(posedge clk);
      #1;
      cyc++;
      bus.rWrite = 1'b0;
      if (toggle) bus.addr = ADDR_W'($urandom);
    end
    checkOutput({tag, "_ready"}, seen, 1);
    checkOutput({tag, "_latency"}, cyc, LATENCY + 1);
    checkOutput({tag, "_busyResp"}, bus.busy, 1);
    checkOutput({tag, "_data"}, bus.rData, expBlock);
    lastBlock = expBlock;
    if (!keepReq) begin
      bus.rRead  = 1'b0;
      bus.rWrite = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, ADDR_W'($urandom), DATA_W'($urandom));
      @(negedge clk);
      checkOutput({tag, "_idleReady"}, bus.ready, 0);
      checkOutput({tag, "_idleBusy"}, bus.busy, 0);
      checkOutput({tag, "_hold"}, bus.rData, lastBlock);
      @(posedge clk);
      #1;
    end
  endtask

`ifdef MEM_RESPONDER_WRITE_EN
  task automatic writeTxn(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input string tag);
    applyStimulus(1'b0, 1'b1, a, d);
    @(negedge clk);
    checkOutput({tag, "_acceptReady"}, bus.ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput({tag, "_ready"}, bus.ready, 1);
    checkOutput({tag, "_busy"}, bus.busy, 1);
    checkOutput({tag, "_hold"}, bus.rData, lastBlock);
    bus.rWrite = 1'b0;
    refMem[a]  = d;
    @(posedge clk);
    #1;
  endtask
`else
  task automatic writeIgnored(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input int n, input string tag);
    applyStimulus(1'b0, 1'b1, a, d);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput({tag, "_ready"}, bus.ready, 0);
      checkOutput({tag, "_busy"}, bus.busy, 0);
      @(posedge clk);
      #1;
    end
    bus.rWrite = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) refMem[i] = DATA_W'(i);
    lastBlock = '0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rstReady", bus.ready, 0);
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstData", bus.rData, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    readTxn(15'h0005, 1'b0, 1'b0, 1'b1, "first");
    checkOutput("firstConst", bus.rData, {32'd7, 32'd6, 32'd5, 32'd4});
    readTxn(15'h7FFE, 1'b0, 1'b0, 1'b0, "topWrap");
    checkOutput("topConst", bus.rData, {32'h7FFF, 32'h7FFE, 32'h7FFD, 32'h7FFC});
    idleCycles(2, "gap0");

`ifdef MEM_RESPONDER_WRITE_EN
    writeTxn(15'h0009, 32'hDEADBEEF, "write9");
    readTxn(15'h0008, 1'b0, 1'b0, 1'b0, "readBack");
    checkOutput("readBackWord1", bus.rData[63:32], 32'hDEADBEEF);
`else
    writeIgnored(15'h0009, 32'hDEADBEEF, 3, "writeOff");
    readTxn(15'h0008, 1'b0, 1'b0, 1'b0, "readBack");
    checkOutput("readBackWord1", bus.rData[63:32], 32'h9);
`endif

    readTxn(15'h0010, 1'b1, 1'b0, 1'b0, "bothReq");
    idleCycles(1, "gap1");
    readTxn(15'h0010, 1'b0, 1'b0, 1'b0, "bothCheck");
    checkOutput("bothWord0", bus.rData[31:0], 32'h10);

    // Reset landing in the second wait cycle must abort silently.
    applyStimulus(1'b1, 1'b0, 15'h0123, '0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst       = 1'b1;
    bus.rRead = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abortBusy", bus.busy, 0);
    checkOutput("abortReady", bus.ready, 0);
    checkOutput("abortData", bus.rData, 0);
    lastBlock = '0;
    @(posedge clk);
    #1;
    idleCycles(6, "abortIdle");
    readTxn(15'h0123, 1'b0, 1'b0, 1'b0, "afterAbort");

    readTxn(15'h0042, 1'b0, 1'b1, 1'b0, "addrToggle");

    for (int n = 0; n < 20; n++) begin
`ifdef MEM_RESPONDER_WRITE_EN
      if ($urandom_range(0, 2) == 0)
        writeTxn(ADDR_W'($urandom), DATA_W'($urandom), "randWrite");
      else
`endif
      readTxn(ADDR_W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'b0, "randRead");
      idleCycles($urandom_range(0, 2), "randGap");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
